// File: rtl/data_mem_controller.sv
// Data memory controller: alignment check, word-bus valid/ready
// transaction, lane shifting, core stall and access fault reporting.
module data_mem_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_enable,
  input  logic        store_enable,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] mem_store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off;
  logic          fault_q;

  logic          req;
  logic [1:0]    size;
  logic          illegal;
  logic          misaligned;
  logic          legal;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;

  assign req  = load_enable | store_enable;
  assign size = func3[1:0];

  assign illegal = (load_enable & store_enable)
                 | (size == 2'b11)
                 | (store_enable & func3[2]);

  assign misaligned = ((size == 2'b01) & address[0])
                    | ((size == 2'b10) & (address[1:0] != 2'b00));

  assign legal = ~illegal & ~misaligned;

  always_comb begin
    be_c = 4'b0000;
    case (size)
      2'b00:   be_c = 4'b0001 << address[1:0];
      2'b01:   be_c = 4'b0011 << address[1:0];
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  assign wdata_c = mem_store_data << {address[1:0], 3'b000};

  // IDLE terms come straight from the request inputs so the core
  // stalls or faults in the same cycle it presents the access.
  assign stall = ((state == IDLE) & req & legal) | (state == REQ);
  assign access_fault = fault_q | ((state == IDLE) & req & ~legal);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      off       <= 2'b00;
      fault_q   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          fault_q <= 1'b0;
          if (req && legal) begin
            state     <= REQ;
            cnt       <= '0;
            bus_req   <= 1'b1;
            bus_we    <= store_enable;
            bus_addr  <= {address[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            off       <= address[1:0];
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (!bus_we) begin
              load_data <= bus_rdata >> {off, 3'b000};
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (TIMEOUT != 0 && cnt == LAST) begin
              bus_req   <= 1'b0;
              fault_q   <= 1'b1;
              load_data <= '0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          fault_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: scoreboarded load/store
// transactions, alignment faults, timeout and reset abort.
module tb_data_mem_controller;

  logic        clk;
  logic        rst;
  logic        load_enable;
  logic        store_enable;
  logic [2:0]  func3;
  logic [31:0] address;
  logic [31:0] mem_store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        access_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  data_mem_controller #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_enable    (load_enable),
    .store_enable   (store_enable),
    .func3          (func3),
    .address        (address),
    .mem_store_data (mem_store_data),
    .load_data      (load_data),
    .stall          (stall),
    .access_fault   (access_fault),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_ready      (bus_ready),
    .bus_rdata      (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One legal access; waits < 0 means the bus never answers.
  task automatic run(input string name, input logic st,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int waits, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd,
                     input logic [31:0] exp_ld, input logic exp_f,
                     input int exp_stall, input int exp_req);
    exp_t e;
    exp_t got;
    int   cyc;
    int   stalls;
    int   reqs;
    bit   done;
    e.data  = exp_ld;
    e.fault = exp_f;
    q.push_back(e);
    load_enable    = ~st;
    store_enable   = st;
    func3          = f3;
    address        = a;
    mem_store_data = wd;
    cyc    = 0;
    stalls = 0;
    reqs   = 0;
    done   = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (stall) stalls++;
      chk({name, " fault_with_req"}, 32'(access_fault & bus_req), 0);
      if (bus_req) begin
        reqs++;
        if (reqs == 1) begin
          chk({name, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
          chk({name, " bus_we"}, 32'(bus_we), 32'(st));
          chk({name, " bus_be"}, 32'(bus_be), 32'(exp_be));
          chk({name, " bus_wdata"}, bus_wdata, exp_wd);
        end
        bus_ready = (waits >= 0) && (reqs > waits);
        bus_rdata = rd;
      end else begin
        bus_ready = 1'b0;
      end
      if (!stall && cyc > 0) begin
        done = 1;
        got  = q.pop_front();
        chk({name, " load_data"}, load_data, got.data);
        chk({name, " access_fault"}, 32'(access_fault), 32'(got.fault));
        load_enable  = 1'b0;
        store_enable = 1'b0;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    chk({name, " completed"}, 32'(done), 1);
    chk({name, " stall_cycles"}, stalls, exp_stall);
    chk({name, " req_cycles"}, reqs, exp_req);
    bus_ready = 1'b0;
  endtask

  task automatic bad(input string name, input logic st,
                     input logic [2:0] f3, input logic [31:0] a);
    load_enable  = ~st;
    store_enable = st;
    func3        = f3;
    address      = a;
    @(negedge clk);
    chk({name, " fault"}, 32'(access_fault), 1);
    chk({name, " stall"}, 32'(stall), 0);
    chk({name, " bus_req"}, 32'(bus_req), 0);
    @(posedge clk);
    #1;
    load_enable  = 1'b0;
    store_enable = 1'b0;
    @(negedge clk);
    chk({name, " fault_gone"}, 32'(access_fault), 0);
    chk({name, " bus_req_after"}, 32'(bus_req), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    load_enable    = 1'b0;
    store_enable   = 1'b0;
    func3          = 3'b000;
    address        = '0;
    mem_store_data = '0;
    bus_ready      = 1'b0;
    bus_rdata      = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset load_data", load_data, 0);
    chk("reset bus_req", 32'(bus_req), 0);
    chk("reset bus_be", 32'(bus_be), 0);
    chk("reset bus_addr", bus_addr, 0);
    chk("reset stall", 32'(stall), 0);
    chk("reset fault", 32'(access_fault), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run("LW", 1'b0, 3'b010, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 0,
        4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1);
    run("SB", 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0, 0,
        4'b1000, 32'hA500_0000, 32'hDEAD_BEEF, 1'b0, 2, 1);
    run("LHU", 1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 3,
        4'b1100, 32'h0, 32'h0000_8001, 1'b0, 5, 4);
    run("SH", 1'b1, 3'b001, 32'h0000_3006, 32'h0000_BEEF, 32'h0, 1,
        4'b1100, 32'hBEEF_0000, 32'h0000_8001, 1'b0, 3, 2);

    bad("SH_mis", 1'b1, 3'b001, 32'h0000_4001);
    bad("LW_mis", 1'b0, 3'b010, 32'h0000_4002);
    bad("LD_ill", 1'b0, 3'b011, 32'h0000_4000);
    bad("SBU_ill", 1'b1, 3'b100, 32'h0000_4000);

    run("LB_tmo", 1'b0, 3'b000, 32'h0000_5001, 32'h0, 32'hFFFF_FFFF, -1,
        4'b0010, 32'h0, 32'h0, 1'b1, 17, 16);

    // Reset while waiting in REQ.
    run("LB", 1'b0, 3'b000, 32'h0000_5003, 32'h0, 32'h7700_0000, 0,
        4'b1000, 32'h0, 32'h0000_0077, 1'b0, 2, 1);
    load_enable  = 1'b1;
    store_enable = 1'b0;
    func3        = 3'b010;
    address      = 32'h0000_5000;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst pre bus_req", 32'(bus_req), 1);
    rst          = 1'b1;
    load_enable  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst bus_req", 32'(bus_req), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst load_data", load_data, 0);
    chk("rst fault", 32'(access_fault), 0);
    @(posedge clk);
    #1;

    run("LW_after", 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h1234_5678, 1,
        4'b1111, 32'h0, 32'h1234_5678, 1'b0, 3, 2);

    chk("scoreboard empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
